// File: rtl/hex_scan_pkg.sv
// Shared types and the hex-to-seven-segment pattern table for the scanned display.
package hex_scan_pkg;

    localparam int SEG_W = 7;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } scan_state_e;

    // Active-high pattern, index 0 = segment a ... index 6 = segment g.
    function automatic logic [0:SEG_W-1] hex_pattern(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_pattern = 7'b1111110;
            4'h1:    hex_pattern = 7'b0110000;
            4'h2:    hex_pattern = 7'b1101101;
            4'h3:    hex_pattern = 7'b1111001;
            4'h4:    hex_pattern = 7'b0110011;
            4'h5:    hex_pattern = 7'b1011011;
            4'h6:    hex_pattern = 7'b1011111;
            4'h7:    hex_pattern = 7'b1110000;
            4'h8:    hex_pattern = 7'b1111111;
            4'h9:    hex_pattern = 7'b1110011;
            4'hA:    hex_pattern = 7'b1110111;
            4'hB:    hex_pattern = 7'b0011111;
            4'hC:    hex_pattern = 7'b1001110;
            4'hD:    hex_pattern = 7'b0111101;
            4'hE:    hex_pattern = 7'b1001111;
            default: hex_pattern = 7'b1000111;
        endcase
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-high seven-segment pattern (a..g).
module hex_seg_decode
    import hex_scan_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [0:SEG_W-1] seg
);

    always_comb begin
        seg = hex_pattern(nibble);
    end

endmodule

// File: rtl/hex_scan_display.sv
// Time-multiplexed seven-segment scanner with gap insertion and frame-synchronous updates.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LZ_BLANK_EN.
module hex_scan_display
    import hex_scan_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned SLOT_CYCLES    = 50000,
    parameter int unsigned GAP_CYCLES     = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    output logic [0:SEG_W-1]      seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done
);

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                pend_vld_q, pend_vld_d;
    logic [4*DIGITS-1:0] act_val_q, act_val_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [0:SEG_W-1]    seg_q, seg_d;
    logic                seg_dp_q, seg_dp_d;
    logic [DIGITS-1:0]   dig_en_q, dig_en_d;
    logic                frame_done_q, frame_done_d;

    logic                slot_wrap;
    logic                frame_wrap;
    scan_state_e         state;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic [DIGITS-1:0]   onehot;
    logic [DIGITS-1:0]   lz_blank;
    logic [0:SEG_W-1]    dec_seg;

    hex_seg_decode u_decode (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    always_comb begin
        slot_wrap  = (cnt_q == SLOT_LAST);
        frame_wrap = slot_wrap && (idx_q == IDX_LAST);
        cnt_d      = slot_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // A load on the boundary cycle stays pending: active takes the old pending first.
    always_comb begin
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        if (frame_wrap && pend_vld_q) begin
            act_val_d = pend_val_q;
            act_dp_d  = pend_dp_q;
        end
        if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp;
            pend_vld_d = 1'b1;
        end else if (frame_wrap) begin
            pend_vld_d = 1'b0;
        end
    end

`ifdef HEX_SCAN_LZ_BLANK_EN
    // A digit blanks when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        logic above_nz;
        lz_blank = '0;
        above_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            above_nz    = above_nz | (act_val_q[4*i +: 4] != 4'h0);
            lz_blank[i] = ~above_nz;
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        state     = (cnt_q < GAP_END) ? GAP : SHOW;
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        onehot    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = act_val_q[4*i +: 4];
                cur_dp    = act_dp_q[i];
                cur_blank = lz_blank[i];
                onehot[i] = 1'b1;
            end
        end

        seg_d    = {SEG_W{SEG_ACTIVE_LOW}};
        seg_dp_d = SEG_ACTIVE_LOW;
        dig_en_d = {DIGITS{DIG_ACTIVE_LOW}};
        if (state == SHOW) begin
            seg_d    = (cur_blank ? '0 : dec_seg) ^ {SEG_W{SEG_ACTIVE_LOW}};
            seg_dp_d = cur_dp ^ SEG_ACTIVE_LOW;
            dig_en_d = onehot ^ {DIGITS{DIG_ACTIVE_LOW}};
        end
        frame_done_d = frame_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_vld_q   <= 1'b0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            seg_q        <= {SEG_W{SEG_ACTIVE_LOW}};
            seg_dp_q     <= SEG_ACTIVE_LOW;
            dig_en_q     <= {DIGITS{DIG_ACTIVE_LOW}};
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_vld_q   <= pend_vld_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            seg_q        <= seg_d;
            seg_dp_q     <= seg_dp_d;
            dig_en_q     <= dig_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign seg_dp     = seg_dp_q;
    assign dig_en     = dig_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display: 4 digits, 8-cycle slots with a 2-cycle gap.
module tb_hex_scan_display;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic [0:6]  seg;
    logic        seg_dp;
    logic [3:0]  dig_en;
    logic        frame_done;

    int n_checks;
    int n_fail;

    hex_scan_display #(
        .DIGITS         (4),
        .SLOT_CYCLES    (8),
        .GAP_CYCLES     (2),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp         (dp),
        .load       (load),
        .seg        (seg),
        .seg_dp     (seg_dp),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [0:6] tb_pat(input logic [3:0] n);
        case (n)
            4'h0: tb_pat = 7'b1111110;
            4'h1: tb_pat = 7'b0110000;
            4'h2: tb_pat = 7'b1101101;
            4'h3: tb_pat = 7'b1111001;
            4'h4: tb_pat = 7'b0110011;
            4'h5: tb_pat = 7'b1011011;
            4'h6: tb_pat = 7'b1011111;
            4'h7: tb_pat = 7'b1110000;
            4'h8: tb_pat = 7'b1111111;
            4'h9: tb_pat = 7'b1110011;
            4'hA: tb_pat = 7'b1110111;
            4'hB: tb_pat = 7'b0011111;
            4'hC: tb_pat = 7'b1001110;
            4'hD: tb_pat = 7'b0111101;
            4'hE: tb_pat = 7'b1001111;
            default: tb_pat = 7'b1000111;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp    = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_fd(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s frame_done: got none, required a pulse within 100 cycles", tag);
        end
    endtask

    // Called on the negedge where frame_done is high (counter 0, digit 0); checks the next 32 cycles.
    task automatic check_frame(input string tag, input logic [15:0] v, input logic [3:0] d,
                               input logic [3:0] blank);
        int s;
        int p;
        logic [0:6] e_seg;
        logic       e_dp;
        logic [3:0] e_en;
        logic       e_fd;
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            s = (j - 1) / 8;
            p = (j - 1) % 8;
            if (p < 2) begin
                e_seg = 7'b1111111;
                e_dp  = 1'b1;
                e_en  = 4'b1111;
            end else begin
                e_en  = ~(4'b0001 << s);
                e_seg = blank[s] ? 7'b1111111 : ~tb_pat(v[4*s +: 4]);
                e_dp  = ~d[s];
            end
            e_fd = (j == 32);
            n_checks += 4;
            if (seg !== e_seg) begin
                n_fail++;
                $display("FAIL %s seg digit=%0d cyc=%0d: got %b required %b", tag, s, p, seg, e_seg);
            end
            if (seg_dp !== e_dp) begin
                n_fail++;
                $display("FAIL %s seg_dp digit=%0d cyc=%0d: got %b required %b", tag, s, p, seg_dp, e_dp);
            end
            if (dig_en !== e_en) begin
                n_fail++;
                $display("FAIL %s dig_en digit=%0d cyc=%0d: got %b required %b", tag, s, p, dig_en, e_en);
            end
            if (frame_done !== e_fd) begin
                n_fail++;
                $display("FAIL %s frame_done j=%0d: got %b required %b", tag, j, frame_done, e_fd);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        n_checks += 4;
        if (seg !== 7'b1111111) begin n_fail++; $display("FAIL reset seg: got %b required 1111111", seg); end
        if (seg_dp !== 1'b1) begin n_fail++; $display("FAIL reset seg_dp: got %b required 1", seg_dp); end
        if (dig_en !== 4'b1111) begin n_fail++; $display("FAIL reset dig_en: got %b required 1111", dig_en); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset frame_done: got %b required 0", frame_done); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        step(3);
        pulse_load(16'h12AF, 4'b0100);
        wait_fd("basic");
        check_frame("basic", 16'h12AF, 4'b0100, 4'b0000);
        check_frame("basic_hold", 16'h12AF, 4'b0100, 4'b0000);
    endtask

    task automatic test_last_wins();
        step(5);
        pulse_load(16'h0001, 4'b0000);
        step(10);
        pulse_load(16'h0002, 4'b0000);
        wait_fd("last_wins");
        check_frame("last_wins", 16'h0002, 4'b0000, 4'b0000);
    endtask

    task automatic test_back_to_back();
        step(3);
        pulse_load(16'h3456, 4'b0001);
        step(27);
        value = 16'hB9E8;
        dp    = 4'b1000;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary_align frame_done: got %b required 1", frame_done);
        end
        check_frame("boundary_old", 16'h3456, 4'b0001, 4'b0000);
        check_frame("boundary_new", 16'hB9E8, 4'b1000, 4'b0000);
    endtask

`ifdef HEX_SCAN_LZ_BLANK_EN
    task automatic test_lz_blank();
        pulse_load(16'h0070, 4'b0000);
        wait_fd("lz_0070");
        check_frame("lz_0070", 16'h0070, 4'b0000, 4'b1100);
        pulse_load(16'h0000, 4'b0010);
        wait_fd("lz_0000");
        check_frame("lz_0000", 16'h0000, 4'b0010, 4'b1110);
    endtask
`endif

    task automatic test_reset_mid();
        pulse_load(16'h5A5A, 4'b0000);
        wait_fd("reset_mid");
        check_frame("reset_mid_pre", 16'h5A5A, 4'b0000, 4'b0000);
        step(20);
        n_checks++;
        if (dig_en !== 4'b1011) begin
            n_fail++;
            $display("FAIL reset_mid showing digit2 dig_en: got %b required 1011", dig_en);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (seg !== 7'b1111111) begin n_fail++; $display("FAIL reset_mid seg: got %b required 1111111", seg); end
        if (seg_dp !== 1'b1) begin n_fail++; $display("FAIL reset_mid seg_dp: got %b required 1", seg_dp); end
        if (dig_en !== 4'b1111) begin n_fail++; $display("FAIL reset_mid dig_en: got %b required 1111", dig_en); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_mid frame_done: got %b required 0", frame_done); end
        @(negedge clk);
        rst_n = 1'b1;
        check_frame("after_reset", 16'h0000, 4'b0000, 4'b0000);
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        value    = '0;
        dp       = '0;
        load     = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_last_wins();
        test_back_to_back();
`ifdef HEX_SCAN_LZ_BLANK_EN
        test_lz_blank();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
